// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: op codes, exception codes,
// FSM encoding and the MEM/WB register payload.
package mem_stage_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned CTRL_OP_W   = 2;
  localparam int unsigned EXP_W       = 3;
  localparam int unsigned MEM_OP_W    = 2;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2
  } mem_op_e;

  localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = CTRL_OP_W'(0);

  localparam logic [EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [EXP_W-1:0] ISA_EXP_BUS_ERR    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] pc;
    logic                   en;
    logic                   br_flag;
    logic [CTRL_OP_W-1:0]   ctrl_op;
    logic [REG_ADDR_W-1:0]  dst_addr;
    logic                   gpr_we_;
    logic [EXP_W-1:0]       exp_code;
    logic [WORD_DATA_W-1:0] out;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_RST = '{
    pc:       WORD_ADDR_W'(0),
    en:       1'b0,
    br_flag:  1'b0,
    ctrl_op:  CTRL_OP_NOP,
    dst_addr: REG_ADDR_W'(0),
    gpr_we_:  1'b1,
    exp_code: ISA_EXP_NO_EXP,
    out:      WORD_DATA_W'(0)
  };

  // Byte address to word address.
  function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [WORD_DATA_W-1:0] byte_addr);
    return byte_addr[WORD_DATA_W-1:2];
  endfunction

endpackage

// File: rtl/mem_stage_mem_reg.sv
// MEM/WB pipeline register: applies stall hold, flush clear and exception muxing,
// and exposes the value it is about to load for forwarding.
module mem_stage_mem_reg
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   busy,
  input  logic                   miss,
  input  logic                   bus_err,
  input  logic                   flushed,
  input  logic                   done,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  mem_wb_t                ex_wb,
  input  logic [WORD_DATA_W-1:0] rd_data,
  output mem_wb_t                q,
  output logic [WORD_DATA_W-1:0] fwd_data
);

  mem_wb_t nxt;

  // Next MEM/WB contents; holds whenever the pipeline is not advancing.
  always_comb begin
    nxt = q;
    if (!stall && !busy) begin
      if (flush || flushed) begin
        nxt = MEM_WB_RST;
      end else if (miss || bus_err) begin
        nxt          = ex_wb;
        nxt.br_flag  = 1'b0;
        nxt.ctrl_op  = CTRL_OP_NOP;
        nxt.gpr_we_  = 1'b1;
        nxt.exp_code = miss ? ISA_EXP_MISS_ALIGN : ISA_EXP_BUS_ERR;
        nxt.out      = WORD_DATA_W'(0);
      end else begin
        nxt = ex_wb;
        // Load data only exists once the bus cycle has finished.
        if (done && (ex_mem_op == MEM_OP_LDW)) begin
          nxt.out = rd_data;
        end
      end
    end
  end

  assign fwd_data = nxt.out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= MEM_WB_RST;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs word loads/stores over a strobe/ready bus with a timeout,
// stalls the pipeline while the access is in flight and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  output logic [WORD_DATA_W-1:0] fwd_data,
  input  logic [WORD_ADDR_W-1:0] ex_pc,
  input  logic                   ex_en,
  input  logic                   ex_br_flag,
  input  logic [MEM_OP_W-1:0]    ex_mem_op,
  input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
  input  logic [CTRL_OP_W-1:0]   ex_ctrl_op,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic                   ex_gpr_we_,
  input  logic [EXP_W-1:0]       ex_exp_code,
  input  logic [WORD_DATA_W-1:0] ex_out,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  output logic [WORD_ADDR_W-1:0] mem_pc,
  output logic                   mem_en,
  output logic                   mem_br_flag,
  output logic [CTRL_OP_W-1:0]   mem_ctrl_op,
  output logic [REG_ADDR_W-1:0]  mem_dst_addr,
  output logic                   mem_gpr_we_,
  output logic [EXP_W-1:0]       mem_exp_code,
  output logic [WORD_DATA_W-1:0] mem_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   bus_err;
  logic                   flushed;
  logic                   is_mem;
  logic                   aligned;
  logic                   req;
  logic                   miss;
  mem_wb_t                ex_wb;
  mem_wb_t                mem_q;

  assign is_mem  = ex_en && (ex_mem_op != MEM_OP_NOP);
  assign aligned = (ex_out[1:0] == 2'b00);
  assign req     = is_mem && (ex_exp_code == ISA_EXP_NO_EXP) && aligned && !flush;
  assign miss    = is_mem && !aligned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pipeline stall request.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          busy      = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (!bus_rdy_ || (cnt == CNT_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!stall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus interface registers, wait counter and per-access status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= CNT_W'(0);
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= WORD_ADDR_W'(0);
      bus_wr_data <= WORD_DATA_W'(0);
      rd_data     <= WORD_DATA_W'(0);
      bus_err     <= 1'b0;
      flushed     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= CNT_W'(0);
          bus_err <= 1'b0;
          flushed <= 1'b0;
          if (req) begin
            bus_addr    <= word_addr(ex_out);
            bus_wr_data <= ex_mem_wr_data;
            bus_rw      <= (ex_mem_op == MEM_OP_LDW);
            bus_as_     <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // A flush cannot abort the bus cycle; remember it and drop the result later.
          if (flush) begin
            flushed <= 1'b1;
          end
          if (!bus_rdy_) begin
            rd_data <= bus_rd_data;
            bus_as_ <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            bus_as_ <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!stall) begin
            cnt     <= CNT_W'(0);
            bus_err <= 1'b0;
            flushed <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_wb = '{
    pc:       ex_pc,
    en:       ex_en,
    br_flag:  ex_br_flag,
    ctrl_op:  ex_ctrl_op,
    dst_addr: ex_dst_addr,
    gpr_we_:  ex_gpr_we_,
    exp_code: ex_exp_code,
    out:      ex_out
  };

  mem_stage_mem_reg u_mem_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .busy      (busy),
    .miss      (miss),
    .bus_err   (bus_err),
    .flushed   (flushed),
    .done      (state == ST_DONE),
    .ex_mem_op (ex_mem_op),
    .ex_wb     (ex_wb),
    .rd_data   (rd_data),
    .q         (mem_q),
    .fwd_data  (fwd_data)
  );

  assign mem_pc       = mem_q.pc;
  assign mem_en       = mem_q.en;
  assign mem_br_flag  = mem_q.br_flag;
  assign mem_ctrl_op  = mem_q.ctrl_op;
  assign mem_dst_addr = mem_q.dst_addr;
  assign mem_gpr_we_  = mem_q.gpr_we_;
  assign mem_exp_code = mem_q.exp_code;
  assign mem_out      = mem_q.out;

endmodule
